// File: rtl/speed_pkg.sv
// speed_pkg: shared speed codes, FSM states and the speed-limit table
package speed_pkg;
  typedef logic [2:0] speed_code_t;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [31:0] SPEED_LIM [0:5] = '{
    32'd200_000_000, 32'd100_000_000, 32'd50_000_000,
    32'd25_000_000, 32'd12_500_000, 32'd5_750_000
  };
endpackage

// File: rtl/speed_classify.sv
// speed_classify: matches a measured period against the limit table, lowest code wins
module speed_classify
  import speed_pkg::*;
#(
  parameter int SIM_DIV = 1,
  parameter int TOL_CYC = 2
) (
  input  logic [31:0] p,
  output logic        hit,
  output speed_code_t code
);
  localparam logic signed [32:0] TOL = 33'(TOL_CYC);
  logic [5:0] ok;
  for (genvar i = 0; i < 6; i++) begin : g_m
    localparam logic signed [32:0] LIM = 33'(SPEED_LIM[i] / SIM_DIV);
    logic signed [32:0] d;
    assign d = $signed({1'b0, p}) - LIM;
    assign ok[i] = (d <= TOL) && (d >= -TOL);
  end
  assign hit = |ok;
  assign code = ok[0] ? 3'd0 : ok[1] ? 3'd1 : ok[2] ? 3'd2 :
                ok[3] ? 3'd3 : ok[4] ? 3'd4 : 3'd5;
endmodule

// File: rtl/speed_decoder.sv
// speed_decoder: recovers the speed code of a free-running counter from its step period
module speed_decoder
  import speed_pkg::*;
#(
  parameter int CNT_BIT = 8,
  parameter int SIM_DIV = 1,
  parameter int TOL_CYC = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [CNT_BIT-1:0] cnt_i,
  output speed_code_t        speed_o,
  output logic               valid_o,
  output logic               upd_o,
  output logic               mismatch_o,
  output logic               err_step_o,
  output logic               timeout_o
);
  localparam logic [31:0] TMO = SPEED_LIM[0] / SIM_DIV + TOL_CYC + 1;
  state_t state, state_d;
  logic [CNT_BIT-1:0] cnt_q;
  logic [31:0] period_cnt;
  logic change, step_ok, hit;
  speed_code_t code, speed_d;
  logic valid_d, upd_d, mis_d, err_d, tmo_d;
  assign change = cnt_i != cnt_q;
  assign step_ok = cnt_i == cnt_q + CNT_BIT'(1);
  speed_classify #(.SIM_DIV(SIM_DIV), .TOL_CYC(TOL_CYC)) u_cls (
    .p(period_cnt), .hit(hit), .code(code)
  );
  always_comb begin
    state_d = state;
    speed_d = speed_o;
    valid_d = valid_o;
    upd_d = 1'b0;
    mis_d = 1'b0;
    err_d = 1'b0;
    tmo_d = 1'b0;
    if (change && !step_ok) begin
      err_d = 1'b1;
      valid_d = 1'b0;
    end else if (change && state == IDLE) begin
      state_d = MEASURE;
    end else if (change) begin
      speed_d = hit ? code : speed_o;
      valid_d = hit;
      upd_d = hit;
      mis_d = !hit;
    end else if (state == MEASURE && period_cnt == TMO) begin
      tmo_d = 1'b1;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_i;
    if (rst_i) begin
      state <= IDLE;
      period_cnt <= '0;
      speed_o <= '0;
      valid_o <= 1'b0;
      upd_o <= 1'b0;
      mismatch_o <= 1'b0;
      err_step_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_d;
      period_cnt <= change ? 32'd1 : (period_cnt == TMO ? TMO : period_cnt + 32'd1);
      speed_o <= speed_d;
      valid_o <= valid_d;
      upd_o <= upd_d;
      mismatch_o <= mis_d;
      err_step_o <= err_d;
      timeout_o <= tmo_d;
    end
  end
endmodule

// File: tb/tb_speed_decoder.sv
// tb_speed_decoder: directed scoreboard bench for speed_decoder at SIM_DIV=100_000
module tb_speed_decoder;
  typedef struct packed {
    logic [2:0] speed;
    logic valid, upd, mis, err, tmo;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cnt = 8'd0;
  logic [2:0] speed_o;
  logic valid_o, upd_o, mismatch_o, err_step_o, timeout_o;
  logic [7:0] obs;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  speed_decoder #(.CNT_BIT(8), .SIM_DIV(100_000), .TOL_CYC(2)) dut (
    .clk_i(clk), .rst_i(rst), .cnt_i(cnt), .speed_o(speed_o), .valid_o(valid_o),
    .upd_o(upd_o), .mismatch_o(mismatch_o), .err_step_o(err_step_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  assign obs = {speed_o, valid_o, upd_o, mismatch_o, err_step_o, timeout_o};
  function automatic exp_t mk(input logic [2:0] s, input logic v, u, m, er, t);
    return {s, v, u, m, er, t};
  endfunction
  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] v, input int gap, input exp_t e);
    logic pulse;
    pulse = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
      pulse |= upd_o | mismatch_o | err_step_o | timeout_o;
    end
    checks++;
    assert (pulse === 1'b0) else begin
      errors++;
      $error("FAIL %s_quiet observed_pulse=%b expected=0", tag, pulse);
    end
    cnt = v;
    sb.push_back(e);
    @(posedge clk); #1;
    check(tag);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    check("reset");
    rst = 1'b0;
    step("ref500", 8'd1, 500, mk(0, 0, 0, 0, 0, 0));
    step("p500a", 8'd2, 500, mk(2, 1, 1, 0, 0, 0));
    step("p500b", 8'd3, 500, mk(2, 1, 1, 0, 0, 0));
    step("p500c", 8'd4, 500, mk(2, 1, 1, 0, 0, 0));
    step("p1002", 8'd5, 1002, mk(1, 1, 1, 0, 0, 0));
    step("p1003", 8'd6, 1003, mk(1, 0, 0, 1, 0, 0));
    step("p57a", 8'd7, 57, mk(5, 1, 1, 0, 0, 0));
    step("p57b", 8'd8, 57, mk(5, 1, 1, 0, 0, 0));
    step("jump", 8'd10, 57, mk(5, 0, 0, 0, 1, 0));
    step("p57c", 8'd11, 57, mk(5, 1, 1, 0, 0, 0));
    step("p59", 8'd12, 59, mk(5, 1, 1, 0, 0, 0));
    step("p60", 8'd13, 60, mk(5, 0, 0, 1, 0, 0));
    step("p55", 8'd14, 55, mk(5, 1, 1, 0, 0, 0));
    step("p54", 8'd15, 54, mk(5, 0, 0, 1, 0, 0));
    step("p2000", 8'd16, 2000, mk(0, 1, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!timeout_o && n < 3000);
    checks++;
    assert (n == 2003) else begin
      errors++;
      $error("FAIL tmo_delay observed=%0d expected=2003", n);
    end
    check("timeout");
    step("idle_bad", 8'd20, 100, mk(0, 0, 0, 0, 1, 0));
    step("idle_ref", 8'd21, 300, mk(0, 0, 0, 0, 0, 0));
    step("relock", 8'd22, 2000, mk(0, 1, 1, 0, 0, 0));
    step("to254", 8'd254, 250, mk(0, 0, 0, 0, 1, 0));
    step("w255", 8'd255, 250, mk(3, 1, 1, 0, 0, 0));
    step("w0", 8'd0, 250, mk(3, 1, 1, 0, 0, 0));
    step("w1", 8'd1, 250, mk(3, 1, 1, 0, 0, 0));
    step("pre_rst", 8'd2, 500, mk(2, 1, 1, 0, 0, 0));
    repeat (299) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    check("mid_rst");
    step("post_ref", 8'd3, 200, mk(0, 0, 0, 0, 0, 0));
    step("post_lock", 8'd4, 500, mk(2, 1, 1, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
